// File: rtl/cnn_pkg.sv
// cnn_pkg
//   Shared helpers for the CNN writeback stages.
//   - cnt_width(n): width of a counter that runs 0..n-1 (never narrower than 1 bit).
//   - requant(x, shift, relu_en, out_w): arithmetic right shift, optional ReLU clamp,
//     then saturation to the signed out_w-bit range. Evaluated in REQ_W bits so that
//     callers with any input width up to REQ_W never see wrap-around.
package cnn_pkg;

  localparam int REQ_W = 32;

  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic logic signed [REQ_W-1:0] requant(
    input logic signed [REQ_W-1:0] x,
    input int                      shift,
    input bit                      relu_en,
    input int                      out_w
  );
    logic signed [REQ_W-1:0] y;
    logic signed [REQ_W-1:0] max_v;
    logic signed [REQ_W-1:0] min_v;
    y     = x >>> shift;
    max_v = (32'sd1 <<< (out_w - 1)) - 32'sd1;
    min_v = -(32'sd1 <<< (out_w - 1));
    if (relu_en && (y < 0)) begin
      y = '0;
    end
    if (y > max_v) begin
      y = max_v;
    end else if (y < min_v) begin
      y = min_v;
    end
    return y;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft
//   Synchronous first-word-fall-through FIFO. The head entry is presented on dout
//   combinationally whenever the FIFO is non-empty; dout is 0 when empty.
//   A push while full is accepted only if a pop happens in the same cycle (the
//   slot being vacated is refilled). A pop while empty is ignored.
// Ports
//   clk    in   clock, all state on rising edge
//   rst_in in   synchronous active-high reset
//   push   in   write din this cycle
//   pop    in   remove head entry this cycle
//   din    in   WIDTH  write data
//   dout   out  WIDTH  head entry (0 when empty)
//   full   out  occupancy == DEPTH
//   empty  out  occupancy == 0
//   count  out  current occupancy
module sync_fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_in,
  input  logic                           push,
  input  logic                           pop,
  input  logic [WIDTH-1:0]               din,
  output logic [WIDTH-1:0]               dout,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mac_result_collector.sv
// mac_result_collector
//   Sits after the MAC. Counts beats of a fixed-length reduction, drives the MAC's
//   accumulate_internal (low on the first beat of each group), requantises the MAC
//   output on the last beat and queues it in a small FWFT FIFO behind a valid/ready
//   interface. Raises stall_out while the FIFO is full so the feeder can hold off.
// Ports
//   clk                     in   clock
//   rst_in                  in   synchronous active-high reset
//   mac_valid_in            in   a MAC beat is issued this cycle
//   mac_out_in              in   IN_WIDTH signed MAC result for this beat
//   accumulate_internal_out out  to MAC; 0 on the first beat of a group
//   stall_out               out  FIFO full
//   result_valid_out        out  result_out holds a valid entry
//   result_ready_in         in   consumer takes result_out this cycle
//   result_out              out  OUT_WIDTH signed requantised result (0 when empty)
//   overflow_err_out        out  sticky: a result was dropped
module mac_result_collector
  import cnn_pkg::*;
#(
  parameter int IN_WIDTH   = 16,
  parameter int OUT_WIDTH  = 8,
  parameter int ACC_LEN    = 9,
  parameter int OUT_SHIFT  = 0,
  parameter int RELU_EN    = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_in,
  input  logic                        mac_valid_in,
  input  logic signed [IN_WIDTH-1:0]  mac_out_in,
  output logic                        accumulate_internal_out,
  output logic                        stall_out,
  output logic                        result_valid_out,
  input  logic                        result_ready_in,
  output logic signed [OUT_WIDTH-1:0] result_out,
  output logic                        overflow_err_out
);

  localparam int CNT_W  = cnt_width(ACC_LEN);
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);

  logic [CNT_W-1:0]     cnt;
  logic                 last_beat;
  logic                 pop;
  logic [OUT_WIDTH-1:0] fifo_din;
  logic [OUT_WIDTH-1:0] fifo_dout;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [FCNT_W-1:0]    fifo_count;

  assign last_beat               = mac_valid_in && (cnt == CNT_W'(ACC_LEN - 1));
  assign accumulate_internal_out = (cnt != '0);
  assign pop                     = result_valid_out && result_ready_in;
  assign result_valid_out        = !fifo_empty;
  assign result_out              = fifo_dout;
  // Registered occupancy only: no path from result_ready_in to stall_out.
  assign stall_out               = (fifo_count == FCNT_W'(FIFO_DEPTH));
  assign fifo_din = OUT_WIDTH'(requant(REQ_W'(mac_out_in), OUT_SHIFT, (RELU_EN != 0), OUT_WIDTH));

  // Beat counter advances on every issued beat, even while stalled or when the
  // group's result ends up dropped, so the MAC stays group-aligned.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      cnt <= '0;
    end else if (mac_valid_in) begin
      cnt <= last_beat ? '0 : cnt + CNT_W'(1);
    end
  end

  // A last beat that finds the FIFO full with nothing leaving loses its result.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      overflow_err_out <= 1'b0;
    end else if (last_beat && fifo_full && !pop) begin
      overflow_err_out <= 1'b1;
    end
  end

  sync_fifo_fwft #(
    .WIDTH (OUT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_in (rst_in),
    .push   (last_beat),
    .pop    (pop),
    .din    (fifo_din),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

endmodule
